// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO
//                registers. Executes MULT, MULTU, DIV and DIVU with a fixed
//                latency of WIDTH+2 edges: one launch edge, WIDTH shift-add
//                or restoring-divide steps, and one sign-fix/writeback edge.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, op           - launch request and opcode (IDLE only)
//                rs_data, rt_data    - multiplicand/dividend, multiplier/divisor
//                abort               - cancels an in-flight op
//                mthi/mtlo, *_wdata  - direct HI/LO writes (IDLE only)
//                hi, lo              - architectural HI/LO
//                busy                - op in flight (registered)
//                done                - one-cycle pulse when new HI/LO visible
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;     // product / quotient must be negated
    logic               r_neg_r;     // remainder must be negated
    logic               r_div0;
    logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits becoming quotient bits}.
    logic [2*WIDTH-1:0] r_acc;

    // ------------------------------------------------------------------
    // Operand conditioning at launch
    // ------------------------------------------------------------------
    logic             w_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;
    logic             w_launch;
    logic             w_fix_wr;

    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_data[WIDTH-1];
    assign w_rt_neg = w_signed & rt_data[WIDTH-1];
    // |MIN| wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
    assign w_rs_abs = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_abs = w_rt_neg ? -rt_data : rt_data;

    assign w_launch = (r_state == S_IDLE) & start & ~abort;
    assign w_fix_wr = (r_state == S_FIX) & ~abort;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Remainder is always < divisor, so the shifted value fits WIDTH+1 bits
    // and the top bit of the difference is a clean borrow flag.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign correction at FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    // Divide by zero: the restoring loop already leaves the dividend
    // magnitude in the remainder; the quotient is forced to all ones.
    assign w_quo_fix  = r_div0  ? {WIDTH{1'b1}}
                      : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start && !abort) w_state_next = S_RUN;
            S_RUN: begin
                if (abort)                       w_state_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))     w_state_next = S_FIX;
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else begin
            busy <= (w_state_next != S_IDLE);
            done <= w_fix_wr;

            if (r_state == S_IDLE) begin
                if (mthi) hi <= hi_wdata;
                if (mtlo) lo <= lo_wdata;
            end

            if (w_launch) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_is_div <= op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_div0   <= op[1] & (rt_data == '0);
                if (op[1]) begin
                    r_opnd <= w_rt_abs;
                    r_acc  <= {{WIDTH{1'b0}}, w_rs_abs};
                end else begin
                    r_opnd <= w_rs_abs;
                    r_acc  <= {{WIDTH{1'b0}}, w_rt_abs};
                end
            end else if ((r_state == S_RUN) && !abort) begin
                r_acc <= r_is_div ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_fix_wr) begin
                if (r_is_div) begin
                    hi <= w_rem_fix;
                    lo <= w_quo_fix;
                end else begin
                    hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in EX and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Exposes busy so the hazard logic can stall IF/ID/EX, and accepts a flush abort from branch/jump redirects.
- Generalises the single-cycle ALU to configurable datapath width and fixed multi-cycle latency.

Parameters:
- WIDTH, 32, operand width and width of each of HI/LO (must be >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to launch op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  input  WIDTH  multiplicand/dividend.
- rt_data  input  WIDTH  multiplier/divisor.
- abort  input  1  flush; cancels an in-flight op.
- mthi  input  1  write hi_wdata into HI.
- mtlo  input  1  write lo_wdata into LO.
- hi_wdata  input  WIDTH  MTHI data.
- lo_wdata  input  WIDTH  MTLO data.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).
- busy  output  1  op in flight; pipeline must stall MFHI/MFLO/MT*/new mul-div.
- done  output  1  one-cycle pulse; hi/lo hold new result this cycle.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Overrides start/abort/mthi/mtlo. Reset mid-op discards the op.
- States: IDLE, RUN, FIX.
- IDLE to RUN: on an edge with start=1 and abort=0. At that edge, latch operands and op. For signed ops, latch the absolute values and the result signs. Set counter=WIDTH and busy=1.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per edge. The counter decrements each step, and the state goes to FIX when the counter reaches 0. RUN lasts exactly WIDTH edges.
- FIX: a single edge that applies sign correction and writes HI/LO. Next state is IDLE. done=1 and busy=0 in the cycle after this edge, when the new hi/lo values are visible.
- Latency: the start edge is edge 0. The result is visible and done=1 after edge WIDTH+1, which is WIDTH+2 edges in total. Latency is fixed and independent of operand values.
- Multiply: the {HI,LO} pair holds the full 2*WIDTH-bit product. MULT is two's-complement signed and MULTU is unsigned.
- Divide: LO = quotient and HI = remainder. DIV truncates toward zero and the remainder takes the sign of the dividend.
- Divide by zero: LO = all ones and HI = dividend. Latency is unchanged.
- Signed overflow (DIV of MIN by -1): LO = MIN and HI = 0.
- abort=1 while busy: the op is cancelled on that edge. State goes to IDLE, busy=0 next cycle, done is never pulsed, and hi/lo are unchanged. abort in IDLE has no effect; a simultaneous start is not accepted.
- start while busy is ignored. There is no queueing.
- mthi/mtlo in IDLE write HI/LO on that edge.
- mthi/mtlo while busy are ignored; the pipeline is responsible for stalling them.
- start, mthi and mtlo in the same IDLE cycle: the MT write takes effect, then the op result overwrites HI/LO at FIX.
- done is 0 in every cycle except the single cycle after FIX.
- busy = (state != IDLE), registered.

Test Plan:
- MULT, WIDTH=32, rs=0xFFFFFFFD (-3), rt=7:
  - busy for 33 cycles, then done pulses 34 edges after start;
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 gives lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) by 2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU 0x1234 by 0: latency is unchanged, lo=0xFFFFFFFF, hi=0x1234.
- Abort and reset mid-op:
  - preload via mthi=0xAA, mtlo=0x55, then start MULTU 5*5;
  - assert abort at cycle 10, so busy=0 next cycle, no done pulse, and hi=0xAA, lo=0x55;
  - start while busy is ignored;
  - rst mid-op gives hi=lo=0 and busy=0.
- WIDTH=8 instance, MULTU 255*255: done 10 edges after start, hi=0xFE, lo=0x01.
